// File: rtl/mfp_uart_pkg.sv
// Shared types and constants for the MFP UART transmitter.
// Optional even-parity support is enabled by defining MFP_UART_TX_PARITY_EN.
package mfp_uart_pkg;

   localparam int   DATA_BITS = 8;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

`ifdef MFP_UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd4
   } tx_state_e;
`endif

   // Clock cycles per bit, rounded to the nearest integer.
   function automatic int calc_divisor(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/mfp_uart_baud_gen.sv
// Restartable bit-period counter: bit_end pulses for one cycle on the last
// clock of every bit period. Holding restart keeps the counter at zero.
module mfp_uart_baud_gen #(
   parameter int DIVISOR = 434
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic restart,
   output logic bit_end
);

   localparam int                 CNT_W = $clog2(DIVISOR);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DIVISOR - 1);

   logic [CNT_W-1:0] baud_cnt;

   assign bit_end = ~restart & (baud_cnt == LAST);

   // Count clocks within the current bit, clearing on restart and at each bit boundary.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         baud_cnt <= '0;
      end else if (restart || bit_end) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter (8E1 when MFP_UART_TX_PARITY_EN is defined) with a
// valid/ready byte interface. The line output is registered, so the start
// bit appears on the same edge that accepts the byte.
module mfp_uart_transmitter
   import mfp_uart_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 UART_TX,
   output logic                 busy
);

   localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD);

   generate
      if (DIVISOR < 2) begin : g_divisor_check
         $error("mfp_uart_transmitter: CLK_HZ/BAUD gives DIVISOR below 2");
      end
   endgenerate

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic                 line_q, line_d;
   logic                 bit_end;
   logic                 accept;
`ifdef MFP_UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   assign accept  = tx_valid & tx_ready;
   assign UART_TX = line_q;

   // The counter sits at zero while idle so the start bit gets a full period.
   mfp_uart_baud_gen #(
      .DIVISOR (DIVISOR)
   ) u_baud_gen (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .restart (state_q == IDLE),
      .bit_end (bit_end)
   );

   // Frame state register; reset abandons any frame in flight.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Advance through the frame one bit period at a time.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)  state_d = START;
         START:   if (bit_end) state_d = DATA;
         DATA: begin
            if (bit_end && bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef MFP_UART_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef MFP_UART_TX_PARITY_EN
         PARITY:  if (bit_end) state_d = STOP;
`endif
         STOP:    if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs and the next line level / shift contents for each state.
   always_comb begin
      tx_ready  = (state_q == IDLE);
      busy      = ~tx_ready;
      line_d    = line_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
`ifdef MFP_UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               line_d    = START_BIT;
               shift_d   = tx_data;
               bit_cnt_d = 3'd0;
`ifdef MFP_UART_TX_PARITY_EN
               parity_d  = ^tx_data;
`endif
            end
         end
         START: begin
            if (bit_end) begin
               line_d  = shift_q[0];
               shift_d = shift_q >> 1;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                  bit_cnt_d = 3'd0;
`ifdef MFP_UART_TX_PARITY_EN
                  line_d    = parity_q;
`else
                  line_d    = STOP_BIT;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  line_d    = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end
         end
`ifdef MFP_UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               line_d = STOP_BIT;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               line_d = 1'b1;
            end
         end
         default: begin
            line_d = 1'b1;
         end
      endcase
   end

   // Registered line level and data path; reset drives the line to idle high at once.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         line_q    <= 1'b1;
         shift_q   <= '0;
         bit_cnt_q <= 3'd0;
`ifdef MFP_UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         line_q    <= line_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
`ifdef MFP_UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Self-checking bench for mfp_uart_transmitter: one instance at default
// rates and one at CLK_HZ=8/BAUD=2, both compared against a frame model.
`timescale 1ns/1ps
module tb_mfp_uart_transmitter;

   localparam int DIV_BIG   = 434;
   localparam int DIV_SMALL = 4;
`ifdef MFP_UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic       HCLK = 1'b0;
   logic       HRESETn = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   bit         use_small = 1'b0;

   logic tx_valid_big, tx_ready_big, uart_tx_big, busy_big;
   logic tx_valid_small, tx_ready_small, uart_tx_small, busy_small;
   logic cur_line, cur_ready, cur_busy;

   int checks = 0;
   int failures = 0;

   assign tx_valid_big   = tx_valid & ~use_small;
   assign tx_valid_small = tx_valid & use_small;
   assign cur_line  = use_small ? uart_tx_small  : uart_tx_big;
   assign cur_ready = use_small ? tx_ready_small : tx_ready_big;
   assign cur_busy  = use_small ? busy_small     : busy_big;

   always #5 HCLK = ~HCLK;

   mfp_uart_transmitter u_dut_big (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .tx_data  (tx_data),
      .tx_valid (tx_valid_big),
      .tx_ready (tx_ready_big),
      .UART_TX  (uart_tx_big),
      .busy     (busy_big)
   );

   mfp_uart_transmitter #(
      .CLK_HZ (8),
      .BAUD   (2)
   ) u_dut_small (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .tx_data  (tx_data),
      .tx_valid (tx_valid_small),
      .tx_ready (tx_ready_small),
      .UART_TX  (uart_tx_small),
      .busy     (busy_small)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Line levels of a whole frame, index 0 = start bit.
   function automatic logic [FRAME_BITS-1:0] expected_frame(input logic [7:0] data);
      logic [FRAME_BITS-1:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) f[1+i] = data[i];
`ifdef MFP_UART_TX_PARITY_EN
      f[9] = (($countones(data) % 2) == 1);
`endif
      f[FRAME_BITS-1] = 1'b1;
      return f;
   endfunction

   // Offer one byte and follow its frame cycle by cycle until the line is idle again.
   task automatic applyStimulus(input logic [7:0] data, input bit keep_valid,
                                input logic [7:0] next_data, input bit inject);
      logic [FRAME_BITS-1:0] frame;
      int div;
      int busy_cycles;
      int level_ok[FRAME_BITS];
      frame = expected_frame(data);
      div = use_small ? DIV_SMALL : DIV_BIG;
      checkOutput("ready_before", cur_ready, 1);
      tx_data  = data;
      tx_valid = 1'b1;
      @(negedge HCLK);
      checkOutput("accept", cur_busy, 1);
      if (!keep_valid) tx_valid = 1'b0;
      tx_data = next_data;
      busy_cycles = 0;
      for (int b = 0; b < FRAME_BITS; b++) level_ok[b] = 0;
      for (int i = 0; i < FRAME_BITS * div; i++) begin
         if (cur_line === frame[i/div]) level_ok[i/div]++;
         if (cur_busy === 1'b1 && cur_ready === 1'b0) busy_cycles++;
         if (inject && i == 3 * div + 1) begin
            tx_data  = 8'hFF;
            tx_valid = 1'b1;
         end else if (inject && i == 3 * div + 2) begin
            tx_valid = 1'b0;
         end
         @(negedge HCLK);
      end
      checkOutput($sformatf("frame_len_%02h", data), busy_cycles, FRAME_BITS * div);
      for (int b = 0; b < FRAME_BITS; b++)
         checkOutput($sformatf("bit%0d_of_%02h", b, data), level_ok[b], div);
      checkOutput("idle_line", cur_line, 1);
      checkOutput("idle_ready", cur_ready, 1);
   endtask

   // Start a frame and pull reset in the middle of data bit 3.
   task automatic abortFrame(input logic [7:0] data);
      int div;
      div = use_small ? DIV_SMALL : DIV_BIG;
      tx_data  = data;
      tx_valid = 1'b1;
      @(negedge HCLK);
      tx_valid = 1'b0;
      repeat (4 * div + div / 2) @(negedge HCLK);
      checkOutput("pre_abort_busy", cur_busy, 1);
      checkOutput("pre_abort_line", cur_line, data[3]);
      HRESETn = 1'b0;
      #1;
      checkOutput("abort_line", cur_line, 1);
      checkOutput("abort_ready", cur_ready, 1);
      checkOutput("abort_busy", cur_busy, 0);
      repeat (2) @(negedge HCLK);
      checkOutput("abort_held_line", cur_line, 1);
      HRESETn = 1'b1;
   endtask

   initial begin
      logic [7:0] cur_byte;
      logic [7:0] nxt_byte;
      bit         keep;

      HRESETn = 1'b0;
      repeat (3) @(negedge HCLK);
      checkOutput("rst_line_big", uart_tx_big, 1);
      checkOutput("rst_ready_big", tx_ready_big, 1);
      checkOutput("rst_busy_big", busy_big, 0);
      checkOutput("rst_line_small", uart_tx_small, 1);
      checkOutput("rst_ready_small", tx_ready_small, 1);
      HRESETn = 1'b1;

      use_small = 1'b0;
      applyStimulus(8'h55, 1'b0, 8'h00, 1'b0);
      applyStimulus(8'hA5, 1'b1, 8'h3C, 1'b0);
      applyStimulus(8'h3C, 1'b0, 8'h00, 1'b0);
      applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
      repeat (2) @(negedge HCLK);
      checkOutput("no_extra_ready", cur_ready, 1);
      checkOutput("no_extra_line", cur_line, 1);
      applyStimulus(8'h07, 1'b0, 8'h00, 1'b0);
      applyStimulus(8'h03, 1'b0, 8'h00, 1'b0);
      abortFrame(8'($urandom) & 8'hF7);
      applyStimulus(8'h81, 1'b0, 8'h00, 1'b0);
      repeat (3) begin
         repeat ($urandom_range(0, 3)) @(negedge HCLK);
         applyStimulus(8'($urandom), 1'b0, 8'($urandom), 1'b0);
      end

      use_small = 1'b1;
      applyStimulus(8'h55, 1'b0, 8'h00, 1'b0);
      abortFrame(8'($urandom) & 8'hF7);
      applyStimulus(8'h81, 1'b0, 8'h00, 1'b0);
      nxt_byte = 8'($urandom);
      for (int n = 0; n < 8; n++) begin
         cur_byte = nxt_byte;
         nxt_byte = 8'($urandom);
         keep = (n < 7) ? bit'($urandom_range(0, 1)) : 1'b0;
         applyStimulus(cur_byte, keep, nxt_byte, (n == 3) && !keep);
         if (!keep) repeat ($urandom_range(1, 3)) @(negedge HCLK);
      end
      tx_valid = 1'b0;
      checkOutput("final_idle_small", cur_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mfp_uart_transmitter.md
MFP_UART_TRANSMITTER -- requirements
Module: mfp_uart_transmitter

Interface
REQ-001 Parameter: CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter: BAUD, default 115200, line bit rate.
REQ-003 HCLK  input  1  single clock; all state sampled on its rising edge.
REQ-004 HRESETn  input  1  reset; asynchronous, active-low.
REQ-005 tx_data  input  8  byte to send; sampled only on accept.
REQ-006 tx_valid  input  1  producer has a byte on tx_data.
REQ-007 tx_ready  output  1  transmitter can accept a byte this cycle.
REQ-008 UART_TX  output  1  serial line; idle high; drives the board UART_TX pin.
REQ-009 busy  output  1  frame in progress (inverse of tx_ready).

Function
REQ-010 DIVISOR SHALL equal (CLK_HZ + BAUD/2) / BAUD, integer; elaboration SHALL fail if DIVISOR < 2.
REQ-011 Defaults SHALL give DIVISOR = 434.
REQ-012 Frame SHALL be: 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-024), 1 stop bit (1); each bit lasts exactly DIVISOR HCLK cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 tx_ready SHALL be 1 only in IDLE; busy = ~tx_ready.
REQ-015 Accept SHALL occur on a rising edge with tx_valid & tx_ready; tx_data is latched into the shift register on that edge; state goes to START.
REQ-016 UART_TX SHALL be registered; it goes low on the edge that accepts the byte; latency from accept edge to start bit = 0 cycles.
REQ-017 Baud counter SHALL restart from 0 on accept and on every bit boundary; a bit ends when counter = DIVISOR-1.
REQ-018 Transitions: START->DATA after 1 bit; DATA->DATA for bits 0..6, DATA->PARITY (if enabled) or STOP after bit 7; PARITY->STOP; STOP->IDLE after the full stop bit.
REQ-019 The cycle after STOP ends SHALL be IDLE with UART_TX = 1 and tx_ready = 1; with tx_valid held high, back-to-back frames are separated by exactly 1 idle cycle.
REQ-020 tx_valid while busy SHALL be ignored; tx_data changes after accept SHALL NOT affect the frame.
REQ-021 Bit counter SHALL be 3 bits and wrap from 7 only via state change; no bit is sent twice or skipped.

Reset
REQ-022 HRESETn low SHALL immediately force: state IDLE, UART_TX = 1, tx_ready = 1, busy = 0, counters 0, shift register 0, including mid-frame; the aborted frame is not resumed.
REQ-023 First accept SHALL be possible on the first rising edge after HRESETn deasserts.

Configuration
REQ-024 Macro MFP_UART_TX_PARITY_EN defined: PARITY state present; parity bit = XOR of the 8 data bits (even parity); frame = 11 bits.
REQ-025 Macro MFP_UART_TX_PARITY_EN undefined: PARITY state and logic absent; DATA goes directly to STOP; frame = 10 bits.

Structure
REQ-026 Package mfp_uart_pkg SHALL hold the FSM state typedef, the frame-bit constants (start = 0, stop = 1, data width 8) and the DIVISOR function.
REQ-027 Sub-module mfp_uart_baud_gen SHALL provide the restartable DIVISOR counter and the one-cycle bit_end pulse.

Verification
REQ-028 Defaults, send 0x55, parity off -> UART_TX low 434 cycles, then 1,0,1,0,1,0,1,0, then stop 1; each level 434 cycles; tx_ready low for 4340 cycles.
REQ-029 tx_valid held, bytes 0xA5 then 0x3C -> second accept exactly 1 cycle after first frame ends; bit order 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
REQ-030 Change tx_data to 0xFF and pulse tx_valid mid-frame of 0x00 -> all 8 data bits 0; no extra frame.
REQ-031 Assert HRESETn low during data bit 3 -> UART_TX = 1 same cycle without clock; after release, accept 0x81 -> full clean frame.
REQ-032 With MFP_UART_TX_PARITY_EN: 0x07 -> parity bit 1, frame 4774 cycles; 0x03 -> parity bit 0; without macro, frame 4340 cycles.
REQ-033 CLK_HZ = 8, BAUD = 2 -> DIVISOR 4; each bit exactly 4 cycles; frame 40 cycles (parity off).
